// File: rtl/apb_mem_slave_wait.sv
// APB slave memory with byte strobes, programmable wait states and error responses
// for unaligned, out-of-range and read-only-region accesses.
module apb_mem_slave_wait #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1,
  parameter int RO_BASE     = 896,
  parameter int RO_LIMIT    = 1023
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic                r_err;
  logic [IDX_W-1:0]    r_index;
  logic [DATA_W-1:0]   r_prdata;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [31:0]         w_index32;
  logic [IDX_W-1:0]    w_idx;
  logic                w_unaligned;
  logic                w_range;
  logic                w_ro;
  logic                w_err;
  logic                w_setup;
  logic                w_complete;

  // Decode is evaluated in 32 bits so the range checks work for any DEPTH/ADDR_W mix
  assign w_index32   = 32'(paddr) >> OFF_W;
  assign w_idx       = w_index32[IDX_W-1:0];
  assign w_unaligned = (32'(paddr) & 32'(BYTES - 1)) != 32'd0;
  assign w_range     = w_index32 >= 32'(DEPTH);
  assign w_ro        = pwrite && (w_index32 >= 32'(RO_BASE)) && (w_index32 <= 32'(RO_LIMIT));
  assign w_err       = w_unaligned || w_range || w_ro;
  assign w_setup     = psel && !penable;
  assign w_complete  = (r_state == S_ACCESS) && (r_cnt == 4'd0) && psel && penable;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_index  <= '0;
      r_prdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(i);
      end
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (w_setup) begin
          r_write  <= pwrite;
          r_err    <= w_err;
          r_index  <= w_idx;
          r_cnt    <= 4'(WAIT_CYCLES);
          r_prdata <= (!pwrite && !w_err) ? r_mem[w_idx] : '0;
        end
      end else begin
        if (psel && (r_cnt != 4'd0)) begin
          r_cnt <= r_cnt - 4'd1;
        end
        if (w_complete && r_write && !r_err) begin
          for (int k = 0; k < BYTES; k++) begin
            if (pstrb[k]) begin
              r_mem[r_index][8*k +: 8] <= pwdata[8*k +: 8];
            end
          end
        end
      end
    end
  end

  // Dropping psel mid-transfer aborts back to IDLE without a write
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel || w_complete) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pready  = 1'b1;
    pslverr = 1'b0;
    if (r_state == S_ACCESS) begin
      pready  = (r_cnt == 4'd0);
      pslverr = r_err && (r_cnt == 4'd0);
    end
  end

  assign prdata = r_prdata;

endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Directed bench for apb_mem_slave_wait: zero-wait, three-wait and byte-wide
// instances driven from a vector table plus abort and mid-transfer reset sequences.
module tb_apb_mem_slave_wait;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        penable;
  logic        pwrite;
  logic [12:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        rdy0, rdy1, rdy2;
  logic        err0, err1, err2;
  logic [31:0] rd0, rd1;
  logic [7:0]  rd2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_mem_slave_wait #(.DATA_W(32), .DEPTH(1024), .ADDR_W(13), .WAIT_CYCLES(0),
                       .RO_BASE(896), .RO_LIMIT(1023)) dutW0 (
    .pclk(clk), .preset(rst), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy0), .prdata(rd0), .pslverr(err0));

  apb_mem_slave_wait #(.DATA_W(32), .DEPTH(1024), .ADDR_W(13), .WAIT_CYCLES(3),
                       .RO_BASE(896), .RO_LIMIT(1023)) dutW3 (
    .pclk(clk), .preset(rst), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy1), .prdata(rd1), .pslverr(err1));

  apb_mem_slave_wait #(.DATA_W(8), .DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(0),
                       .RO_BASE(896), .RO_LIMIT(1023)) dut8 (
    .pclk(clk), .preset(rst), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr[7:0]), .pwdata(pwdata[7:0]), .pstrb(pstrb[0:0]),
    .pready(rdy2), .prdata(rd2), .pslverr(err2));

  typedef struct {
    int          dut;
    logic        wr;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] expRd;
    logic        expErr;
    int          expCyc;
  } vec_t;

  vec_t tbl[32];
  int   nVec = 0;
  int   splitIdx = 0;

  task automatic addVec(input int d, input logic wr, input logic [12:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] er, input logic ee, input int ec);
    tbl[nVec] = '{d, wr, a, wd, st, er, ee, ec};
    nVec++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sampleOut(input int d, output logic r, output logic [31:0] dat, output logic e);
    case (d)
      0:       begin r = rdy0; dat = rd0; e = err0; end
      1:       begin r = rdy1; dat = rd1; e = err1; end
      default: begin r = rdy2; dat = {24'h0, rd2}; e = err2; end
    endcase
  endtask

  // One complete APB transfer; counts setup plus every access cycle up to pready
  task automatic applyStimulus(input int d, input logic wr, input logic [12:0] a,
                               input logic [31:0] wd, input logic [3:0] st,
                               output logic [31:0] rdOut, output logic errOut, output int cycles);
    logic        r;
    logic [31:0] dat;
    logic        e;
    bit          done;
    @(negedge clk);
    sel = 3'b000;
    sel[d] = 1'b1;
    penable = 1'b0;
    pwrite = wr;
    paddr = a;
    pwdata = wd;
    pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    cycles = 2;
    done = 1'b0;
    r = 1'b0;
    dat = '0;
    e = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sampleOut(d, r, dat, e);
      if (r) begin
        done = 1'b1;
        break;
      end
      cycles++;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: pready stayed 0, expected 1 within 40 cycles");
    end
    rdOut = dat;
    errOut = e;
    @(negedge clk);
    sel = 3'b000;
    penable = 1'b0;
  endtask

  task automatic runVec(input int i);
    logic [31:0] rdv;
    logic        ev;
    int          cyc;
    applyStimulus(tbl[i].dut, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, rdv, ev, cyc);
    checkOutput($sformatf("vec%0d prdata", i), rdv, tbl[i].expRd);
    checkOutput($sformatf("vec%0d pslverr", i), {31'b0, ev}, {31'b0, tbl[i].expErr});
    checkOutput($sformatf("vec%0d cycles", i), 32'(cyc), 32'(tbl[i].expCyc));
  endtask

  initial begin
    rst = 1'b1;
    sel = 3'b000;
    penable = 1'b0;
    pwrite = 1'b0;
    paddr = '0;
    pwdata = '0;
    pstrb = '0;

    // zero-wait 32-bit instance
    addVec(0, 1'b0, 13'h010, 32'h0, 4'h0, 32'h0000_0004, 1'b0, 2);
    addVec(0, 1'b0, 13'hFFC, 32'h0, 4'h0, 32'h0000_03FF, 1'b0, 2);
    addVec(0, 1'b1, 13'h010, 32'h0123_4567, 4'hF, 32'h0, 1'b0, 2);
    addVec(0, 1'b0, 13'h010, 32'h0, 4'h0, 32'h0123_4567, 1'b0, 2);
    addVec(0, 1'b0, 13'h002, 32'h0, 4'h0, 32'h0, 1'b1, 2);
    // three-wait 32-bit instance
    addVec(1, 1'b1, 13'h020, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 5);
    addVec(1, 1'b0, 13'h020, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 5);
    addVec(1, 1'b1, 13'h020, 32'h1122_3344, 4'h5, 32'h0, 1'b0, 5);
    addVec(1, 1'b0, 13'h020, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0, 5);
    addVec(1, 1'b0, 13'h003, 32'h0, 4'h0, 32'h0, 1'b1, 5);
    addVec(1, 1'b0, 13'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 5);
    addVec(1, 1'b1, 13'hE10, 32'h0000_0055, 4'hF, 32'h0, 1'b1, 5);
    addVec(1, 1'b0, 13'hE10, 32'h0, 4'h0, 32'h0000_0384, 1'b0, 5);
    addVec(1, 1'b1, 13'hDFC, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0, 5);
    addVec(1, 1'b0, 13'hDFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 5);
    addVec(1, 1'b1, 13'hFFC, 32'h0000_0077, 4'hF, 32'h0, 1'b1, 5);
    addVec(1, 1'b0, 13'hFFC, 32'h0, 4'h0, 32'h0000_03FF, 1'b0, 5);
    addVec(1, 1'b1, 13'h014, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0, 5);
    addVec(1, 1'b0, 13'h014, 32'h0, 4'h0, 32'hAAAA_5555, 1'b0, 5);
    splitIdx = nVec;
    // after mid-write reset: memory back to identity contents
    addVec(1, 1'b0, 13'h014, 32'h0, 4'h0, 32'h0000_0005, 1'b0, 5);
    addVec(1, 1'b0, 13'h020, 32'h0, 4'h0, 32'h0000_0008, 1'b0, 5);
    // byte-wide instance
    addVec(2, 1'b1, 13'h007, 32'h0000_00A5, 4'h1, 32'h0, 1'b0, 2);
    addVec(2, 1'b0, 13'h007, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, 2);
    addVec(2, 1'b0, 13'h009, 32'h0, 4'h0, 32'h0000_0009, 1'b0, 2);
    addVec(2, 1'b0, 13'h0FF, 32'h0, 4'h0, 32'h0000_00FF, 1'b0, 2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset pready", {31'b0, rdy0}, 32'd1);
    checkOutput("reset prdata", rd0, 32'd0);
    checkOutput("reset pslverr", {31'b0, err0}, 32'd0);
    checkOutput("reset pready w3", {31'b0, rdy1}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < splitIdx; i++) begin
      runVec(i);
    end

    // master abort during wait cycles of a write to word 16
    @(negedge clk);
    sel = 3'b010;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 13'h040;
    pwdata = 32'hCAFE_F00D;
    pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    checkOutput("abort wait pready", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    sel = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    checkOutput("abort idle pready", {31'b0, rdy1}, 32'd1);
    checkOutput("abort idle pslverr", {31'b0, err1}, 32'd0);
    begin
      logic [31:0] rdv;
      logic        ev;
      int          cyc;
      applyStimulus(1, 1'b0, 13'h040, 32'h0, 4'h0, rdv, ev, cyc);
      checkOutput("abort word16 prdata", rdv, 32'd16);
      checkOutput("abort word16 cycles", 32'(cyc), 32'd5);
    end

    // reset asserted while a write to word 5 is waiting
    @(negedge clk);
    sel = 3'b010;
    penable = 1'b0;
    pwrite = 1'b1;
    paddr = 13'h014;
    pwdata = 32'h1234_5678;
    pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    checkOutput("midreset wait pready", {31'b0, rdy1}, 32'd0);
    rst = 1'b1;
    sel = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    checkOutput("midreset pready", {31'b0, rdy1}, 32'd1);
    checkOutput("midreset prdata", rd1, 32'd0);
    checkOutput("midreset pslverr", {31'b0, err1}, 32'd0);
    rst = 1'b0;

    for (int i = splitIdx; i < nVec; i++) begin
      runVec(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time 200000, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb_mem_slave_wait.md
# apb_mem_slave_wait

Parametrised APB slave memory: the next-generation on-chip memory peripheral behind the APB bus. It generalises data width and depth and adds byte strobes, programmable wait states through `pready`, and error signalling on `pslverr`. Error responses cover unaligned, out-of-range and read-only-region accesses. Targets debug/CTF challenge fabrics where a bus master or eavesdropper reads and writes word-addressed storage.

## Interface
Parameters:
- `DATA_W`, 32: data bus width; multiple of 8, minimum 8.
- `DEPTH`, 1024: number of `DATA_W` words.
- `ADDR_W`, 12: byte-address width of `paddr`.
- `WAIT_CYCLES`, 1: `pready`-low cycles inserted per access; 0–15.
- `RO_BASE`, 896: first word index of the read-only region.
- `RO_LIMIT`, 1023: last word index of the read-only region, inclusive. Setting `RO_LIMIT` < `RO_BASE` disables the region.

Ports:
- `pclk`, in, 1: sole clock; all logic on the rising edge.
- `preset`, in, 1: synchronous, active-high reset.
- `psel`, in, 1: slave select.
- `penable`, in, 1: access phase.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, `ADDR_W`: byte address.
- `pwdata`, in, `DATA_W`: write data.
- `pstrb`, in, `DATA_W/8`: byte-lane write strobes.
- `pready`, out, 1: transfer-complete / ready.
- `prdata`, out, `DATA_W`: read data, registered.
- `pslverr`, out, 1: error response; valid only while `pready`=1 in the access phase.

## Operation
- Word index = `paddr >> log2(DATA_W/8)`. Byte offset = the low `log2(DATA_W/8)` bits.
- Error conditions, evaluated and latched at the setup edge:
  - byte offset ≠ 0 (unaligned);
  - word index ≥ `DEPTH`;
  - write with index in [`RO_BASE`, `RO_LIMIT`].
- FSM states and transitions:
  - IDLE → ACCESS on `psel`=1 & `penable`=0. This edge latches `pwrite`, the index and the error flag, and loads the wait counter with `WAIT_CYCLES`.
  - For a non-error read, this same edge loads `prdata` with `mem[index]`. For an error read or any write, it loads `prdata` with 0.
  - ACCESS with counter > 0: decrement. `pready`=0.
  - ACCESS with counter = 0: `pready`=1. On `psel`&`penable`, the transfer completes → IDLE.
  - ACCESS with `psel`=0 (master abort) → IDLE. No write.
  - `penable`=1 while in IDLE is ignored.
- Write commit occurs on the completing edge only, and only if there is no error. For each lane k with `pstrb[k]`=1, `mem[index][8k+7:8k]` ← `pwdata[8k+7:8k]`. Unstrobed lanes are unchanged.
- An error write leaves memory untouched.
- The write uses `pwdata`/`pstrb` as sampled on the completing edge.
- Memory reset: every word i ← i, truncated to `DATA_W`.

## Timing
- Reset values: `pready`=1, `prdata`=0, `pslverr`=0, FSM=IDLE, counter=0.
- `preset` dominates everything. A transfer in flight is dropped with no write, and memory is reinitialised.
- `pready` is derived combinationally from the state and counter:
  - 1 in IDLE;
  - 0 in ACCESS while counter > 0;
  - 1 in ACCESS when counter = 0.
- `pslverr` = latched error flag AND state=ACCESS AND counter=0. Otherwise 0.
- Transfer length:
  - `WAIT_CYCLES`=0: 2 cycles (setup + access). Zero-wait, as on the current memory peripheral.
  - `WAIT_CYCLES`=N: N+2 cycles.
- `prdata` is valid from the first access cycle and holds until the next setup edge.
- Back-to-back transfers: after a completion, the next setup is accepted on the following cycle, giving no dead cycle beyond APB's mandatory setup phase.
- Read-after-write to the same index in back-to-back transfers returns the newly written data. The write commits before the next setup edge samples memory.

## Test plan
- Reset, `DATA_W`=32, `WAIT_CYCLES`=0 → `pready`=1, `prdata`=0, `pslverr`=0. Read `paddr`=0x010 returns 4 in 2 cycles with `pslverr`=0.
- `WAIT_CYCLES`=3: write 0xDEADBEEF to 0x020 with `pstrb`=0xF → `pready` is low for exactly 3 access cycles, then high. A following read of 0x020 returns 0xDEADBEEF in 5 cycles.
- Partial strobe: word 8 holds 0xDEADBEEF; write 0x11223344 with `pstrb`=0b0101 → read returns 0xDE22BE44.
- Errors:
  - read of 0x003 (unaligned) → `pslverr`=1, `prdata`=0;
  - read of index 1024 (`paddr`=0x1000 with `ADDR_W`=13) → `pslverr`=1;
  - write 0x55 to index 900 → `pslverr`=1, and a subsequent read returns 900.
- Master abort: drop `psel` during wait cycles of a write to 0x040 → FSM returns to IDLE and index 16 still reads 16. Assert `preset` mid-write → all outputs return to reset values and memory is reinitialised.
- `DATA_W`=8, `DEPTH`=256: write 0xA5 to byte address 7, then read back → 0xA5 with `pslverr`=0.
